instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  single-cycle pulse that begins a load session; honoured only in IDLE.
REQ-004 base_addr  input  10  first instruction-memory address of the session, sampled on start.
REQ-005 length  input  10  number of instructions to write in the session, sampled on start.
REQ-006 req_valid  input  1  encode request present.
REQ-007 req_ready  output  1  loader accepts the request this cycle.
REQ-008 req_itype  input  1  1 = I-type, 0 = R-type.
REQ-009 req_op  input  4  rOp (R-type) or {x, iOp} (I-type).
REQ-010 req_field  input  5  operand field: register index [3:0] (R-type) or immediate [4:0] (I-type).
REQ-011 im_we  output  1  instruction-memory write request.
REQ-012 im_ready  input  1  memory accepts the write this cycle.
REQ-013 im_addr  output  10  write address.
REQ-014 im_wdata  output  9  encoded instruction word.
REQ-015 busy  output  1  high in LOAD.
REQ-016 done  output  1  one-cycle pulse when the session completes.
REQ-017 err_illegal  output  1  sticky flag for a rejected illegal encoding; cleared by the next start.

Function
REQ-018 The encoding SHALL be R-type {1'b0, req_field[3:0], req_op[3:0]} and I-type {1'b1, req_field[4:0], req_op[2:0]}.
REQ-019 For R-type, req_field[4] SHALL be ignored; for I-type, req_op[3] SHALL be ignored.
REQ-020 An I-type request with iOp 3'b110 or 3'b111 SHALL be consumed, not written, and SHALL set err_illegal; it does not count toward length.
REQ-021 A request transfer SHALL occur on a cycle with req_valid && req_ready.
REQ-022 States SHALL be IDLE, LOAD and DONE.
REQ-023 IDLE->LOAD on start with length != 0; IDLE->DONE on start with length == 0; DONE->IDLE unconditionally after one cycle.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 Legal accepted words SHALL enter a 2-entry FIFO; im_we = LOAD && FIFO non-empty, and im_wdata SHALL be the FIFO head.
REQ-026 A write SHALL complete on im_we && im_ready; the FIFO then pops, im_addr increments and the written count increments.
REQ-027 im_addr SHALL wrap from 1023 to 0.
REQ-028 req_ready = LOAD && FIFO not full && (accepted legal count < length).
REQ-029 A word accepted at edge N SHALL be presented on im_we no earlier than cycle N+1.
REQ-030 Simultaneous push and pop on a full FIFO SHALL NOT occur: req_ready is low when the FIFO is full.
REQ-031 Simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-032 LOAD->DONE SHALL occur on the edge where the written count reaches length; done is high for exactly the DONE cycle.
REQ-033 im_addr, im_wdata and im_we SHALL be stable while im_we && !im_ready.

Reset
REQ-034 While rst_n is low, the block SHALL be in IDLE with the FIFO empty, the counts at 0, and im_addr, im_wdata, im_we, busy, done, req_ready and err_illegal all at 0.
REQ-035 Reset asserted mid-session SHALL abort the session immediately; pending FIFO words are discarded and no write completes after reset.

Structure
REQ-036 The type-code bit position, the rOp/iOp encodings, the field widths and the 10-bit address width SHALL be defined in the shared ISA package used by the control decoder.
REQ-037 The 2-entry FIFO SHALL be a sub-module named instr_fifo; the FSM, counters and encoder remain in instr_loader.

Verification
REQ-038 start, base_addr=0x010, length=3; R ADD field=2, I ADDI imm=5, R SW field=1; im_ready=1 -> writes 0x020@0x010, 0x128@0x011, 0x019@0x012; done pulses once.
REQ-039 I-type iOp=3'b110 inside a length=1 session, followed by R XOR field=3 -> err_illegal=1 and only 0x034 is written.
REQ-040 base_addr=1023, length=2 -> writes at 1023 then 0.
REQ-041 im_ready held low for 5 cycles with a full FIFO -> req_ready=0, im_addr/im_wdata stable, no request lost.
REQ-042 start with length=0 -> done high on the next cycle, no im_we.
REQ-043 rst_n pulled low after the first of 3 writes -> outputs zero, state IDLE; a new start writes from the new base.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared ISA definitions for the instruction loader and
// the control decoder.
//   - instruction word layout (type-code bit, field widths)
//   - rOp / iOp encodings
//   - loader FSM state type
//   - encode() builds a 9-bit word; iop_illegal() flags reserved iOps
package instr_loader_pkg;

  localparam int ADDR_W     = 10;  // instruction-memory address width
  localparam int WORD_W     = 9;   // encoded instruction width
  localparam int TYPE_BIT   = 8;   // 1 = I-type, 0 = R-type
  localparam int ROP_W      = 4;
  localparam int IOP_W      = 3;
  localparam int REG_W      = 4;   // R-type register index
  localparam int IMM_W      = 5;   // I-type immediate
  localparam int OP_IN_W    = 4;   // request op port width
  localparam int FIELD_IN_W = 5;   // request field port width

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [ROP_W-1:0] {
    ROP_ADD = 4'd0,
    ROP_SUB = 4'd1,
    ROP_AND = 4'd2,
    ROP_OR  = 4'd3,
    ROP_XOR = 4'd4,
    ROP_SLL = 4'd5,
    ROP_SRL = 4'd6,
    ROP_SLT = 4'd7,
    ROP_LW  = 4'd8,
    ROP_SW  = 4'd9,
    ROP_BEQ = 4'd10,
    ROP_JR  = 4'd11
  } rop_e;

  typedef enum logic [IOP_W-1:0] {
    IOP_ADDI = 3'd0,
    IOP_ANDI = 3'd1,
    IOP_ORI  = 3'd2,
    IOP_LUI  = 3'd3,
    IOP_BEQZ = 3'd4,
    IOP_JMP  = 3'd5,
    IOP_RSV6 = 3'd6,   // reserved, illegal
    IOP_RSV7 = 3'd7    // reserved, illegal
  } iop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // R-type: {0, reg[3:0], rOp[3:0]}   I-type: {1, imm[4:0], iOp[2:0]}
  // Unused input bits (field[4] for R, op[3] for I) are dropped here.
  function automatic word_t encode(input logic                  itype,
                                   input logic [OP_IN_W-1:0]    op,
                                   input logic [FIELD_IN_W-1:0] field);
    word_t w;
    w           = '0;
    w[TYPE_BIT] = itype;
    if (itype) begin
      w[TYPE_BIT-1 -: IMM_W] = field[IMM_W-1:0];
      w[IOP_W-1:0]           = op[IOP_W-1:0];
    end else begin
      w[TYPE_BIT-1 -: REG_W] = field[REG_W-1:0];
      w[ROP_W-1:0]           = op[ROP_W-1:0];
    end
    return w;
  endfunction

  function automatic logic iop_illegal(input logic [IOP_W-1:0] iop);
    return (iop == IOP_RSV6) || (iop == IOP_RSV7);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: 2-entry FIFO holding encoded words between request accept
// and instruction-memory write.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write side; push is ignored when full
//   pop        : read side; pop is ignored when empty
//   rdata      : current head (valid when !empty)
//   empty/full : occupancy flags
module instr_fifo
  import instr_loader_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);
  assign rdata = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // push+pop together leaves occupancy unchanged
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts encode requests during a load session, encodes
// them into 9-bit instruction words and writes them to consecutive
// instruction-memory addresses starting at base_addr.
//   start/base_addr/length   : session launch (honoured only in IDLE)
//   req_valid/req_ready/...  : encode request handshake
//   im_we/im_ready/im_addr/im_wdata : instruction-memory write handshake
//   busy  : high while loading
//   done  : one-cycle pulse when the session completes
//   err_illegal : sticky, set by a reserved I-type iOp, cleared by start
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] base_addr,
  input  logic [9:0] length,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_itype,
  input  logic [3:0] req_op,
  input  logic [4:0] req_field,
  output logic       im_we,
  input  logic       im_ready,
  output logic [9:0] im_addr,
  output logic [8:0] im_wdata,
  output logic       busy,
  output logic       done,
  output logic       err_illegal
);

  state_e state_q, state_d;
  addr_t  addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] acc_cnt_q, acc_cnt_d;  // legal words accepted
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;    // words written to memory
  logic   err_q, err_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic   in_load;
  logic   is_illegal;
  logic   req_xfer;
  logic   fifo_push, fifo_pop;
  logic   fifo_empty, fifo_full;
  word_t  fifo_head;
  word_t  enc_word;

  assign in_load    = (state_q == ST_LOAD);
  assign is_illegal = req_itype && iop_illegal(req_op[IOP_W-1:0]);
  assign enc_word   = encode(req_itype, req_op, req_field);

  // Accept only while room remains both in the FIFO and in the session.
  assign req_ready = in_load && !fifo_full && (acc_cnt_q < len_q);
  assign req_xfer  = req_valid && req_ready;

  // Illegal words are consumed but never reach the FIFO.
  assign fifo_push = req_xfer && !is_illegal;

  assign im_we    = in_load && !fifo_empty;
  assign fifo_pop = im_we && im_ready;
  assign im_addr  = addr_q;
  assign im_wdata = im_we ? fifo_head : '0;

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_illegal = err_q;

  instr_fifo #(.WIDTH(WORD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          len_d     = length;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
          err_d     = 1'b0;
          state_d   = (length != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (req_xfer && is_illegal) err_d = 1'b1;
        if (fifo_push) acc_cnt_d = acc_cnt_q + 1'b1;
        if (fifo_pop) begin
          addr_d   = addr_q + 1'b1;  // natural wrap 1023 -> 0
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q + 1'b1 == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Registered decodes of the next state so busy/done are flop outputs.
    busy_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader. Requests and the
// writes they should produce are queued together; a monitor pops expected
// writes as the memory handshake completes.
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] base_addr;
  logic [9:0] length;
  logic       req_valid;
  logic       req_ready;
  logic       req_itype;
  logic [3:0] req_op;
  logic [4:0] req_field;
  logic       im_we;
  logic       im_ready;
  logic [9:0] im_addr;
  logic [8:0] im_wdata;
  logic       busy;
  logic       done;
  logic       err_illegal;

  always #5 clk = ~clk;

  instr_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_itype   (req_itype),
    .req_op      (req_op),
    .req_field   (req_field),
    .im_we       (im_we),
    .im_ready    (im_ready),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal)
  );

  typedef struct {
    logic       itype;
    logic [3:0] op;
    logic [4:0] field;
  } req_t;

  typedef struct {
    logic [9:0] addr;
    logic [8:0] data;
  } wr_t;

  req_t req_q[$];
  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   ready_mode = 1;  // 0 = low, 1 = high, 2 = random

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] enc(input logic it, input logic [3:0] op, input logic [4:0] f);
    return it ? {1'b1, f, op[2:0]} : {1'b0, f[3:0], op};
  endfunction

  task automatic add_req(input logic it, input logic [3:0] op, input logic [4:0] f);
    req_t r;
    r.itype = it; r.op = op; r.field = f;
    req_q.push_back(r);
  endtask

  task automatic add_exp(input logic [9:0] a, input logic [8:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_q.push_back(w);
  endtask

  // Request source and memory-ready driver.
  initial begin
    bit   taken;
    req_t r;
    req_valid = 1'b0; req_itype = 1'b0; req_op = '0; req_field = '0;
    im_ready  = 1'b1;
    forever begin
      @(negedge clk);
      taken = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (taken && req_q.size() > 0) void'(req_q.pop_front());
      case (ready_mode)
        0:       im_ready = 1'b0;
        2:       im_ready = 1'($urandom_range(0, 1));
        default: im_ready = 1'b1;
      endcase
      if (req_q.size() > 0) begin
        r = req_q[0];
        req_valid = 1'b1;
        req_itype = r.itype;
        req_op    = r.op;
        req_field = r.field;
      end else begin
        req_valid = 1'b0;
      end
    end
  end

  // Write monitor: scoreboard compare and stall-stability checks.
  initial begin
    logic       stall;
    logic [9:0] pa;
    logic [8:0] pd;
    wr_t        e;
    stall = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall) begin
          chk("stall_we", im_we, 1);
          chk("stall_addr", im_addr, pa);
          chk("stall_data", im_wdata, pd);
        end
        if (done) done_cnt++;
        if (im_we && im_ready) begin
          chk("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", im_addr, e.addr);
            chk("wr_data", im_wdata, e.data);
          end
        end
        stall = im_we && !im_ready;
        pa = im_addr;
        pd = im_wdata;
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [9:0] b, input logic [9:0] l);
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic end_session(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_all_written"}, exp_q.size(), 0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_err"}, err_illegal, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       it;
    logic [3:0] op;
    logic [4:0] f;
    bit         got_first;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Three-word session; op[3] of the I-type and field[4] of SW are don't-cares
    add_req(1'b0, 4'd0, 5'd2);        add_exp(10'h010, 9'h020);
    add_req(1'b1, 4'b1000, 5'd5);     add_exp(10'h011, 9'h128);
    add_req(1'b0, 4'd9, 5'b10001);    add_exp(10'h012, 9'h019);
    done_cnt = 0;
    do_start(10'h010, 10'd3);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    wait_done("t1_done_seen", 50);
    end_session("t1");

    // Illegal iOp consumed without a write; only the XOR lands
    add_req(1'b1, 4'b1110, 5'd7);
    add_req(1'b0, 4'd4, 5'd3);        add_exp(10'h040, 9'h034);
    done_cnt = 0;
    do_start(10'h040, 10'd1);
    wait_done("t2_done_seen", 50);
    end_session("t2");
    chk("t2_err_set", err_illegal, 1);

    // Address wrap 1023 -> 0; start clears the sticky error
    add_req(1'b0, 4'd1, 5'h0A);       add_exp(10'h3FF, 9'h0A1);
    add_req(1'b0, 4'd2, 5'h0F);       add_exp(10'h000, 9'h0F2);
    done_cnt = 0;
    do_start(10'h3FF, 10'd2);
    @(negedge clk);
    chk("t3_err_cleared", err_illegal, 0);
    wait_done("t3_done_seen", 50);
    end_session("t3");

    // Memory back-pressure with a full FIFO
    add_req(1'b0, 4'd3, 5'd4);        add_exp(10'h100, 9'h043);
    add_req(1'b1, 4'd1, 5'h1F);       add_exp(10'h101, 9'h1F9);
    add_req(1'b0, 4'd5, 5'd6);        add_exp(10'h102, 9'h065);
    add_req(1'b1, 4'd2, 5'd0);        add_exp(10'h103, 9'h102);
    ready_mode = 0;
    done_cnt = 0;
    do_start(10'h100, 10'd4);
    repeat (8) @(negedge clk);
    chk("t4_ready_low", req_ready, 0);
    chk("t4_we_held", im_we, 1);
    chk("t4_addr_held", im_addr, 10'h100);
    chk("t4_data_held", im_wdata, 9'h043);
    chk("t4_reqs_pending", req_q.size(), 2);
    ready_mode = 1;
    wait_done("t4_done_seen", 50);
    end_session("t4");

    // Zero-length session
    done_cnt = 0;
    do_start(10'h055, 10'd0);
    @(negedge clk);
    chk("t5_done_next", done, 1);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    chk("t5_done_once", done_cnt, 1);
    chk("t5_done_low", done, 0);
    chk("t5_no_write", im_we, 0);

    // Random legal/illegal mix with random memory ready across the wrap
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 2) == 0) add_req(1'b1, 4'($urandom_range(6, 7)), 5'($urandom));
      it = 1'($urandom);
      op = 4'($urandom);
      f  = 5'($urandom);
      if (it && op[2:1] == 2'b11) op[1] = 1'b0;
      add_req(it, op, f);
      add_exp(10'h3FD + 10'(i), enc(it, op, f));
    end
    done_cnt = 0;
    do_start(10'h3FD, 10'd6);
    wait_done("t6_done_seen", 300);
    end_session("t6");
    ready_mode = 1;

    // Reset after the first of three writes aborts the session
    add_req(1'b0, 4'd8, 5'd1);        add_exp(10'h200, 9'h018);
    add_req(1'b0, 4'd2, 5'd2);
    add_req(1'b0, 4'd3, 5'd3);
    do_start(10'h200, 10'd3);
    got_first = 0;
    for (int i = 0; i < 20 && !got_first; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) got_first = 1;
    end
    chk("t7_first_write", got_first, 1);
    rst_n = 1'b0;
    req_q.delete();
    @(negedge clk);
    chk_idle_zero("t7_rst");
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_idle_after_rst", busy, 0);
    add_req(1'b0, 4'd7, 5'd3);        add_exp(10'h300, 9'h037);
    done_cnt = 0;
    do_start(10'h300, 10'd1);
    wait_done("t7_done_seen", 50);
    end_session("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
